// File: rtl/cv32e40s_pkg.sv
// Shared types for the instruction-side arbiter: FSM state encoding and the
// response payload that the OBI instruction interface returns.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } instr_arb_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } inst_resp_t;

endpackage

// File: rtl/cv32e40s_instr_arb_tracker.sv
// Outstanding-transaction and flush-discard bookkeeping for the instruction
// arbiter; decides whether an incoming response is kept or dropped.
module cv32e40s_instr_arb_tracker #(
  parameter int MAX_OUTSTND = 2,
  parameter int CNT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept_i,
  input  logic                 resp_valid_i,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] discard_cnt_o,
  output logic                 resp_keep_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] discard_cnt_q, discard_cnt_d;
  logic                 resp_legal;

  assign resp_legal = resp_valid_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (accept_i && !resp_valid_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!accept_i && resp_legal) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // A flush discards everything already accepted; a response arriving in the
  // flush cycle is still delivered, so it is excluded from the discard count.
  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (flush_i) begin
      discard_cnt_d = resp_legal ? (cnt_q - CNT_WIDTH'(1)) : cnt_q;
    end else if (resp_valid_i && (discard_cnt_q != '0)) begin
      discard_cnt_d = discard_cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      discard_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_valid_i && (cnt_q == '0)))
        else $error("instr arbiter: response received with no outstanding transaction");
    end
  end

  assign cnt_o         = cnt_q;
  assign discard_cnt_o = discard_cnt_q;
  assign resp_keep_o   = resp_legal && (discard_cnt_q == '0);

endmodule

// File: rtl/cv32e40s_instr_if_arbiter.sv
// Shares the instruction transaction interface between the prefetcher (req0)
// and an auxiliary fetch client (req1). Define CV32E40S_INSTR_ARB_RR_EN for round-robin.
module cv32e40s_instr_if_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int MAX_OUTSTND = 2,
  parameter int CNT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid_i,
  input  logic [31:0]          req0_addr_i,
  output logic                 req0_ready_o,
  input  logic                 req0_flush_i,
  output logic                 req0_rvalid_o,
  input  logic                 req1_valid_i,
  input  logic [31:0]          req1_addr_i,
  output logic                 req1_ready_o,
  input  logic                 req1_flush_i,
  output logic                 req1_rvalid_o,
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  output logic [31:0]          trans_addr_o,
  input  logic                 resp_valid_i,
  input  inst_resp_t           resp_i,
  output inst_resp_t           resp_o,
  output logic [CNT_WIDTH-1:0] outstnd_cnt_o,
  output logic                 busy_o
);

  instr_arb_state_e     state_q, state_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] cnt, discard_cnt;
  logic                 cnt_lt_max, gnt0, gnt1, yield0, yield1;
  logic                 accept, flush, resp_keep, drain_done;

  assign cnt_lt_max = (cnt < CNT_WIDTH'(MAX_OUTSTND));

`ifdef CV32E40S_INSTR_ARB_RR_EN
  logic last_q, last_d;   // 1: req1 was granted most recently

  assign yield0 = req1_valid_i;
  assign yield1 = req0_valid_i;
`else
  assign yield0 = 1'b0;
  assign yield1 = req0_valid_i;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && cnt_lt_max) begin
      case (state_q)
        IDLE: begin
`ifdef CV32E40S_INSTR_ARB_RR_EN
          if (req0_valid_i && req1_valid_i) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
          end
`else
          gnt0 = req0_valid_i;
          gnt1 = req1_valid_i && !req0_valid_i;
`endif
        end
        OWN0:    gnt0 = req0_valid_i && !yield0;
        OWN1:    gnt1 = req1_valid_i && !yield1;
        default: ;
      endcase
    end
  end

  assign trans_valid_o = gnt0 || gnt1;
  assign trans_addr_o  = gnt0 ? req0_addr_i : (gnt1 ? req1_addr_i : 32'h0);
  assign accept        = trans_valid_o && trans_ready_i;
  assign req0_ready_o  = gnt0 && trans_ready_i;
  assign req1_ready_o  = gnt1 && trans_ready_i;

  assign flush = !rst && (((state_q == OWN0) && req0_flush_i) ||
                          ((state_q == OWN1) && req1_flush_i));

  cv32e40s_instr_arb_tracker #(
    .MAX_OUTSTND (MAX_OUTSTND),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .accept_i      (accept),
    .resp_valid_i  (resp_valid_i),
    .flush_i       (flush),
    .cnt_o         (cnt),
    .discard_cnt_o (discard_cnt),
    .resp_keep_o   (resp_keep)
  );

  assign req0_rvalid_o = !rst && resp_keep && (state_q == OWN0);
  assign req1_rvalid_o = !rst && resp_keep && (state_q == OWN1);
  assign resp_o        = resp_i;

  // Counter reaches zero in this cycle with nothing new accepted.
  assign drain_done = !accept &&
                      ((cnt == '0) || ((cnt == CNT_WIDTH'(1)) && resp_valid_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = gnt0 ? OWN0 : OWN1;
      OWN0, OWN1: if (drain_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef CV32E40S_INSTR_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && accept) last_d = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (discard_cnt <= cnt)
        else $error("instr arbiter: discard count exceeds outstanding count");
    end
  end

  assign outstnd_cnt_o = cnt;
  assign busy_o        = busy_q;

endmodule
